sram_wr_sched: RTL and testbench

Write-side scheduler for the global-buffer SRAM bank. It monitors the per-block `Wr_Req` flags of `NUM_SRAM` block controllers and picks one EMPTY block round-robin. It runs the `State_Wr` / `SRAMIF_Wr_ID` / `IFSRAM_Conf_rdy` request handshake, then streams `Wr_Len` words from a valid/ready source into that block. It finishes with a one-hot `write_SRAM_done` pulse. It sits between the off-chip interface data path and the bank of SRAM block controllers.

---
 rtl/sram_wr_sched.sv | 186 ++++++++++++++++++
 tb/tb_sram_wr_sched.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_wr_sched.sv
// sram_wr_sched
// Write-side scheduler for the global-buffer SRAM bank.
//
// Purpose:
//   Picks one EMPTY SRAM block, using a round-robin search over Wr_Req.
//   Runs the request/configuration handshake with the interface.
//   Streams Wr_Len words from a valid/ready source into the granted block.
//   Ends each transfer with a one-hot write_SRAM_done pulse.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             synchronous soft clear (aborts any transfer, no done)
//   Wr_Req            per-block EMPTY flags (bit i = block i may be written)
//   IFSRAM_Conf_rdy   interface ready; moves WR_REQ_READY -> WR_WRITE
//   Wr_Len            transfer length in words, sampled on the Conf_rdy cycle
//   in_valid/in_data  source word
//   in_ready          high while in WR_WRITE
//   State_Wr          FSM state (00 idle, 01 request ready, 11 write)
//   SRAMIF_Wr_ID      granted block ID, zero-extended to 6 bits
//   write_en          one-hot per-block write strobe (registered)
//   addr_w, data_in   write address / data, registered with write_en
//   write_SRAM_done   one-hot completion pulse, same cycle as last write_en
//   busy              FSM not idle
//
// Handshake: a source word transfers on every rising clock edge where
// in_valid and in_ready are both high. in_ready does not depend on
// in_valid. The source may drop in_valid at any time; a cycle without a
// transfer writes nothing and leaves the word counter unchanged.

module sram_wr_sched #(
    parameter int NUM_SRAM   = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int PORT_WIDTH = 128,
    parameter int SRAM_DEPTH = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [NUM_SRAM-1:0]   Wr_Req,
    input  logic                  IFSRAM_Conf_rdy,
    input  logic [ADDR_WIDTH:0]   Wr_Len,
    input  logic                  in_valid,
    input  logic [PORT_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [1:0]            State_Wr,
    output logic [5:0]            SRAMIF_Wr_ID,
    output logic [NUM_SRAM-1:0]   write_en,
    output logic [ADDR_WIDTH-1:0] addr_w,
    output logic [PORT_WIDTH-1:0] data_in,
    output logic [NUM_SRAM-1:0]   write_SRAM_done,
    output logic                  busy
);

    localparam int ID_W  = $clog2(NUM_SRAM);
    localparam int LEN_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        WR_IDLE      = 2'b00,
        WR_REQ_READY = 2'b01,
        WR_WRITE     = 2'b11
    } wr_state_e;

    wr_state_e             state_q;
    logic [ID_W-1:0]       id_q;
    logic [ID_W-1:0]       ptr_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      cnt_q;
    logic [NUM_SRAM-1:0]   write_en_q;
    logic [NUM_SRAM-1:0]   done_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [PORT_WIDTH-1:0] data_q;

    logic [ID_W-1:0]     grant_id_d;
    logic                grant_vld_d;
    logic [ID_W:0]       rr_sum;
    logic [ID_W-1:0]     rr_idx;
    logic [LEN_W-1:0]    len_d;
    logic [ID_W-1:0]     ptr_d;
    logic [NUM_SRAM-1:0] id_onehot;
    logic                last_word;

    // Round-robin search. Scan offsets from the highest down to zero so
    // that the smallest offset from ptr_q (the first set bit at or above
    // ptr_q, wrapping round) is the one written last and wins.
    always_comb begin
        grant_id_d  = ptr_q;
        grant_vld_d = 1'b0;
        rr_sum      = '0;
        rr_idx      = '0;
        for (int i = NUM_SRAM - 1; i >= 0; i--) begin
            rr_sum = {1'b0, ptr_q} + (ID_W + 1)'(i);
            if (rr_sum >= (ID_W + 1)'(NUM_SRAM)) begin
                rr_sum = rr_sum - (ID_W + 1)'(NUM_SRAM);
            end
            rr_idx = rr_sum[ID_W-1:0];
            if (Wr_Req[rr_idx]) begin
                grant_id_d  = rr_idx;
                grant_vld_d = 1'b1;
            end
        end
    end

    // A length of zero, or one larger than a block, means a full block.
    always_comb begin
        len_d = Wr_Len;
        if ((Wr_Len == '0) || (Wr_Len > LEN_W'(SRAM_DEPTH))) begin
            len_d = LEN_W'(SRAM_DEPTH);
        end
    end

    always_comb begin
        ptr_d = id_q + ID_W'(1);
        if (id_q == ID_W'(NUM_SRAM - 1)) begin
            ptr_d = '0;
        end
    end

    assign id_onehot = NUM_SRAM'(1) << id_q;
    assign last_word = (cnt_q == (len_q - LEN_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WR_IDLE;
            id_q       <= '0;
            ptr_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            write_en_q <= '0;
            done_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            // Strobes and done are single-cycle pulses unless set below.
            write_en_q <= '0;
            done_q     <= '0;
            if (start) begin
                state_q <= WR_IDLE;
                cnt_q   <= '0;
                ptr_q   <= '0;
            end else begin
                case (state_q)
                    WR_IDLE: begin
                        if (grant_vld_d) begin
                            id_q    <= grant_id_d;
                            state_q <= WR_REQ_READY;
                        end
                    end
                    WR_REQ_READY: begin
                        if (IFSRAM_Conf_rdy) begin
                            len_q   <= len_d;
                            cnt_q   <= '0;
                            state_q <= WR_WRITE;
                        end
                    end
                    WR_WRITE: begin
                        if (in_valid) begin
                            write_en_q <= id_onehot;
                            addr_q     <= cnt_q[ADDR_WIDTH-1:0];
                            data_q     <= in_data;
                            cnt_q      <= cnt_q + LEN_W'(1);
                            if (last_word) begin
                                // The done pulse is registered together
                                // with the last strobe, so both appear in
                                // the same cycle.
                                state_q <= WR_IDLE;
                                ptr_q   <= ptr_d;
                                done_q  <= id_onehot;
                            end
                        end
                    end
                    default: state_q <= WR_IDLE;
                endcase
            end
        end
    end

    assign State_Wr        = state_q;
    assign SRAMIF_Wr_ID    = 6'(id_q);
    assign write_en        = write_en_q;
    assign addr_w          = addr_q;
    assign data_in         = data_q;
    assign write_SRAM_done = done_q;
    assign in_ready        = (state_q == WR_WRITE);
    assign busy            = (state_q != WR_IDLE);

endmodule

// File: tb/tb_sram_wr_sched.sv
// tb_sram_wr_sched
// Directed bench for sram_wr_sched. It covers the following cases:
//   - reset values;
//   - round-robin grant order;
//   - bubbles on in_valid;
//   - a delayed Conf_rdy;
//   - a soft-clear abort;
//   - a full-block transfer with Wr_Len = 0.
// Every word the bench transfers pushes the expected strobe, done, address
// and data onto exp_q. A monitor on the falling edge pops one entry for
// each strobe or done pulse it sees and compares the two.

module tb_sram_wr_sched;

    localparam int N     = 16;
    localparam int AW    = 9;
    localparam int PW    = 128;
    localparam int DEPTH = 512;
    localparam int EW    = N + N + AW + PW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [N-1:0]  Wr_Req = '0;
    logic          IFSRAM_Conf_rdy = 1'b0;
    logic [AW:0]   Wr_Len = '0;
    logic          in_valid = 1'b0;
    logic [PW-1:0] in_data = '0;
    logic          in_ready;
    logic [1:0]    State_Wr;
    logic [5:0]    SRAMIF_Wr_ID;
    logic [N-1:0]  write_en;
    logic [AW-1:0] addr_w;
    logic [PW-1:0] data_in;
    logic [N-1:0]  write_SRAM_done;
    logic          busy;

    always #5 clk = ~clk;

    sram_wr_sched #(
        .NUM_SRAM  (N),
        .ADDR_WIDTH(AW),
        .PORT_WIDTH(PW),
        .SRAM_DEPTH(DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .Wr_Req         (Wr_Req),
        .IFSRAM_Conf_rdy(IFSRAM_Conf_rdy),
        .Wr_Len         (Wr_Len),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .State_Wr       (State_Wr),
        .SRAMIF_Wr_ID   (SRAMIF_Wr_ID),
        .write_en       (write_en),
        .addr_w         (addr_w),
        .data_in        (data_in),
        .write_SRAM_done(write_SRAM_done),
        .busy           (busy)
    );

    int total = 0;
    int bad   = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_obs;
    logic [EW-1:0] mon_exp;

    int   cyc = 0;
    int   strobe_cnt = 0;
    int   done_cnt = 0;
    int   first_we_cyc = 0;
    int   done_cyc = 0;
    logic prev_we = 1'b0;

    always @(posedge clk) cyc++;

    // Scoreboard: every strobe or done pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if ((write_en != '0) || (write_SRAM_done != '0)) begin
            mon_obs = {write_en, write_SRAM_done, addr_w, data_in};
            if (exp_q.size() == 0) mon_exp = '0;
            else mon_exp = exp_q.pop_front();
            total++;
            assert (mon_obs === mon_exp) else begin
                bad++;
                $error("FAIL strobe obs=%h exp=%h", mon_obs, mon_exp);
            end
        end
        if (write_en != '0) begin
            strobe_cnt++;
            if (!prev_we) first_we_cyc = cyc;
        end
        if (write_SRAM_done != '0) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_we = |write_en;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input string tag);
        int n = 0;
        while ((State_Wr !== s) && (n < 2000)) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(State_Wr), 64'(s));
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0) && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // Offer words from a falling edge while in WR_WRITE. vpat bit k is
    // in_valid on step k (steps beyond 31 are always valid). Stops after
    // nwords transfers.
    task automatic stream(input int len, input int nwords, input logic [31:0] vpat,
                          input int id);
        int       k = 0;
        int       step = 0;
        logic     v;
        logic [N-1:0] oh;
        oh = N'(1) << id;
        while ((k < nwords) && (step < 2000)) begin
            v = (step < 32) ? vpat[step] : 1'b1;
            in_valid = v;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            if (v && in_ready) begin
                exp_q.push_back({oh, (k == len - 1) ? oh : N'(0), AW'(k), in_data});
                k++;
            end
            step++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("stream_words", 64'(k), 64'(nwords));
    endtask

    initial begin
        int s0;
        int d0;
        int c0;
        int e0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_state", 64'(State_Wr), 64'd0);
        check("rst_id", 64'(SRAMIF_Wr_ID), 64'd0);
        check("rst_we", 64'(write_en), 64'd0);
        check("rst_done", 64'(write_SRAM_done), 64'd0);
        check("rst_addr", 64'(addr_w), 64'd0);
        check("rst_data", 64'(data_in[63:0]), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic transfer: block 2, four words, no bubbles
        Wr_Req = 16'h0004;
        Wr_Len = 10'd4;
        IFSRAM_Conf_rdy = 1'b1;
        wait_state(2'b01, "t1_grant");
        check("t1_id", 64'(SRAMIF_Wr_ID), 64'd2);
        Wr_Req = '0;
        wait_state(2'b11, "t1_write");
        e0 = cyc;
        s0 = strobe_cnt;
        d0 = done_cnt;
        stream(4, 4, 32'hFFFF_FFFF, 2);
        drain("t1_drain");
        wait_state(2'b00, "t1_idle");
        check("t1_strobes", 64'(strobe_cnt - s0), 64'd4);
        check("t1_dones", 64'(done_cnt - d0), 64'd1);
        check("t1_latency", 64'(done_cyc - e0), 64'd4);
        check("t1_busy", 64'(busy), 64'd0);
        check("t1_ready", 64'(in_ready), 64'd0);

        // Round-robin order 0..15 from a cleared pointer
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        Wr_Req = 16'hFFFF;
        Wr_Len = 10'd1;
        for (int i = 0; i < N; i++) begin
            wait_state(2'b01, "t2_grant");
            check("t2_id", 64'(SRAMIF_Wr_ID), 64'(i));
            Wr_Req[i] = 1'b0;
            wait_state(2'b11, "t2_write");
            stream(1, 1, 32'hFFFF_FFFF, i);
        end
        drain("t2_drain");
        wait_state(2'b00, "t2_idle");
        check("t2_id_hold", 64'(SRAMIF_Wr_ID), 64'd15);

        // Bubbles on in_valid: pattern 1,0,0,1,1
        Wr_Req = 16'h0100;
        Wr_Len = 10'd3;
        wait_state(2'b01, "t3_grant");
        check("t3_id", 64'(SRAMIF_Wr_ID), 64'd8);
        Wr_Req = '0;
        wait_state(2'b11, "t3_write");
        s0 = strobe_cnt;
        d0 = done_cnt;
        stream(3, 3, 32'hFFFF_FFF9, 8);
        drain("t3_drain");
        wait_state(2'b00, "t3_idle");
        check("t3_strobes", 64'(strobe_cnt - s0), 64'd3);
        check("t3_dones", 64'(done_cnt - d0), 64'd1);

        // Conf_rdy held low for five cycles after the grant
        IFSRAM_Conf_rdy = 1'b0;
        Wr_Req = 16'h0020;
        Wr_Len = 10'd2;
        wait_state(2'b01, "t4_grant");
        check("t4_id", 64'(SRAMIF_Wr_ID), 64'd5);
        Wr_Req = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_state", 64'(State_Wr), 64'd1);
            check("t4_hold_we", 64'(write_en), 64'd0);
        end
        IFSRAM_Conf_rdy = 1'b1;
        c0 = cyc;
        wait_state(2'b11, "t4_write");
        stream(2, 2, 32'hFFFF_FFFF, 5);
        drain("t4_drain");
        check("t4_first_strobe", 64'(first_we_cyc - c0), 64'd2);
        wait_state(2'b00, "t4_idle");

        // Soft clear after two of eight words
        Wr_Req = 16'h0800;
        Wr_Len = 10'd8;
        wait_state(2'b01, "t5_grant");
        check("t5_id", 64'(SRAMIF_Wr_ID), 64'd11);
        Wr_Req = '0;
        wait_state(2'b11, "t5_write");
        d0 = done_cnt;
        stream(8, 2, 32'hFFFF_FFFF, 11);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t5_state", 64'(State_Wr), 64'd0);
        check("t5_we", 64'(write_en), 64'd0);
        check("t5_done", 64'(write_SRAM_done), 64'd0);
        drain("t5_drain");
        check("t5_no_done", 64'(done_cnt - d0), 64'd0);

        // Pointer cleared: search from 0 picks block 4 over block 11.
        // Wr_Len = 0 means a full block.
        Wr_Req = 16'h0810;
        Wr_Len = 10'd0;
        wait_state(2'b01, "t6_grant");
        check("t6_id", 64'(SRAMIF_Wr_ID), 64'd4);
        Wr_Req = '0;
        wait_state(2'b11, "t6_write");
        s0 = strobe_cnt;
        d0 = done_cnt;
        stream(DEPTH, DEPTH, 32'hFFFF_FFFF, 4);
        drain("t6_drain");
        wait_state(2'b00, "t6_idle");
        check("t6_strobes", 64'(strobe_cnt - s0), 64'(DEPTH));
        check("t6_dones", 64'(done_cnt - d0), 64'd1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
